// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//   Physical-memory responder at the far end of the pmem line interface.
//   Accepts one 256-bit line read or write at a time and answers with a
//   single-cycle pmem_resp LATENCY cycles after the request is accepted.
//   Lines live in an on-chip array. The array is not reset, so its contents
//   survive rst_n.
//
// Handshake: the initiator raises pmem_read or pmem_write (plus address and
//   wdata) and holds them until it sees pmem_resp. It drops them in the cycle
//   after pmem_resp. If both request lines drop while the responder is busy,
//   the request is aborted: there is no pmem_resp, a pending write is not
//   committed, and pmem_error pulses once. If read and write are both high at
//   acceptance, the request runs as a write and pmem_error pulses in the
//   cycle after acceptance.
//
// Parameters
//   DEPTH_LINES : number of 32-byte lines (power of two, >= 2)
//   LATENCY     : cycles from acceptance to pmem_resp (>= 1)
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   pmem_read/write     : request strobes, held until pmem_resp
//   pmem_address[31:0]  : byte address; line index = addr[5 +: log2(DEPTH_LINES)]
//   pmem_wdata[255:0]   : write line
//   pmem_rdata[255:0]   : read line, valid in the pmem_resp cycle of a read
//   pmem_resp           : one-cycle completion pulse
//   pmem_error          : one-cycle protocol-violation pulse
//   dbg_state[1:0]      : current FSM state (IDLE=0, BUSY=1, RESP=2)
//   rd_count, wr_count  : completed read/write counters, saturating
//                         (present only when PMEM_RESP_STATS_EN is defined)
//
// Optional feature macro: PMEM_RESP_STATS_EN
module pmem_line_responder #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_error,
  output logic [1:0]   dbg_state
`ifdef PMEM_RESP_STATS_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_wr;
  logic [IDX_W-1:0]   idx;
  logic [255:0]       wdata_q;
  logic [255:0]       mem [DEPTH_LINES];

  logic [IDX_W-1:0]   req_idx;
  logic               req_any;
  logic               unused_addr_bits;

  assign req_idx          = pmem_address[5 +: IDX_W];
  assign req_any          = pmem_read | pmem_write;
  assign dbg_state        = state;
  // Offset bits and bits above the index field do not select a line.
  assign unused_addr_bits = ^pmem_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdata_q    <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      pmem_error <= 1'b0;
    end else begin
      pmem_resp  <= 1'b0;
      pmem_error <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            // Write wins when both strobes are high; flag the violation.
            op_wr      <= pmem_write;
            idx        <= req_idx;
            wdata_q    <= pmem_wdata;
            pmem_error <= pmem_read & pmem_write;
            if (LATENCY == 1) begin
              state     <= RESP;
              pmem_resp <= 1'b1;
              if (!pmem_write) pmem_rdata <= mem[req_idx];
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (!req_any) begin
            // Initiator gave up: drop the request without committing.
            state      <= IDLE;
            cnt        <= '0;
            pmem_error <= 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            // Counter reaches 0 on this edge; the response cycle follows.
            state     <= RESP;
            cnt       <= '0;
            pmem_resp <= 1'b1;
            if (!op_wr) pmem_rdata <= mem[idx];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write commits at the end of the RESP cycle.
  always_ff @(posedge clk) begin
    if (state == RESP && op_wr) mem[idx] <= wdata_q;
  end

`ifdef PMEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESP) begin
      if (op_wr) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule
